mips_decode_queue: RTL and testbench

- Buffered, pipelined decode stage between fetch and execute.
- Accepts raw 32-bit MIPS instructions with their PC into a DEPTH-entry FIFO.
- Decodes the FIFO head and presents registered control signals through a valid/ready output slot.
- Tracks a syscall halt state; supports flush.

---
 rtl/mips_decode_queue.sv | 236 +++++++++++++++++++++++
 tb/tb_mips_decode_queue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : mips_decode_queue
// Purpose  : Buffered decode stage. Raw MIPS instructions and their PCs are
//            queued in a DEPTH-entry FIFO. The FIFO head is decoded
//            combinationally and captured into a registered valid/ready
//            output slot. An issued syscall can halt the block (SYS_HALT).
//            Flush discards all queued and decoded work and clears the halt.
// Option   : MIPS_DECODE_PERF_EN adds the perf_issued / perf_ri counters.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_ADDU 4'd1
`define ALU_SUB  4'd2
`define ALU_SUBU 4'd3
`define ALU_AND  4'd4
`define ALU_OR   4'd5
`define ALU_XOR  4'd6
`endif

module mips_decode_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_W     = 32,
  parameter bit SYS_HALT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [4:0]             out_rs,
  output logic [4:0]             out_rt,
  output logic [4:0]             out_rd,
  output logic [31:0]            out_imm,
  output logic [3:0]             out_alu_sel,
  output logic                   out_alu_src,
  output logic                   out_we,
  output logic                   out_dst_rt,
  output logic                   out_sys,
  output logic                   out_ri,
  output logic                   halted,
`ifdef MIPS_DECODE_PERF_EN
  output logic [31:0]            perf_issued,
  output logic [15:0]            perf_ri,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [31:0]       inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;

  logic              valid_q, src_q, we_q, dst_q, sys_q, ri_q;
  logic [PC_W-1:0]   pc_q;
  logic [4:0]        rs_q, rt_q, rd_q;
  logic [31:0]       imm_q;
  logic [3:0]        alu_q;

  logic              full, empty, push, hs, halting, load;
  logic [31:0]       head_inst;
  logic [3:0]        dec_alu;
  logic              dec_src, dec_we, dec_dst, dec_sys, dec_ri, dec_zext;
  logic [31:0]       dec_imm;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full && (state_q == ST_RUN);
  assign push      = in_valid && in_ready;
  assign hs        = valid_q && out_ready;
  // A halting syscall handshake must not pull the next instruction into the slot.
  assign halting   = SYS_HALT && hs && sys_q;
  assign load      = !empty && (state_q == ST_RUN) && (!valid_q || out_ready) && !halting;
  assign head_inst = inst_mem[rd_ptr_q];

  // Combinational decode of the FIFO head.
  always_comb begin
    dec_alu  = `ALU_ADD;
    dec_src  = 1'b0;
    dec_we   = 1'b0;
    dec_dst  = 1'b0;
    dec_sys  = 1'b0;
    dec_ri   = 1'b0;
    dec_zext = 1'b0;
    case (head_inst[31:26])
      6'h00: begin
        dec_we = 1'b1;
        case (head_inst[5:0])
          6'h20:   dec_alu = `ALU_ADD;
          6'h21:   dec_alu = `ALU_ADDU;
          6'h22:   dec_alu = `ALU_SUB;
          6'h23:   dec_alu = `ALU_SUBU;
          6'h24:   dec_alu = `ALU_AND;
          6'h25:   dec_alu = `ALU_OR;
          6'h26:   dec_alu = `ALU_XOR;
          6'h0C: begin dec_sys = 1'b1; dec_we = 1'b0; end
          default: begin dec_ri = 1'b1; dec_we = 1'b0; end
        endcase
      end
      6'h08: begin dec_we = 1'b1; dec_src = 1'b1; dec_dst = 1'b1; dec_alu = `ALU_ADD;  end
      6'h09: begin dec_we = 1'b1; dec_src = 1'b1; dec_dst = 1'b1; dec_alu = `ALU_ADDU; end
      6'h0C: begin dec_we = 1'b1; dec_src = 1'b1; dec_dst = 1'b1; dec_alu = `ALU_AND; dec_zext = 1'b1; end
      6'h0D: begin dec_we = 1'b1; dec_src = 1'b1; dec_dst = 1'b1; dec_alu = `ALU_OR;  dec_zext = 1'b1; end
      6'h0E: begin dec_we = 1'b1; dec_src = 1'b1; dec_dst = 1'b1; dec_alu = `ALU_XOR; dec_zext = 1'b1; end
      default: dec_ri = 1'b1;
    endcase
    dec_imm = dec_zext ? {16'h0000, head_inst[15:0]} : {{16{head_inst[15]}}, head_inst[15:0]};
  end

  // FIFO storage; needs no reset because the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= in_inst;
      pc_mem[wr_ptr_q]   <= in_pc;
    end
  end

  // FIFO pointers and occupancy; flush empties the queue outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (load) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, load})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Output slot: capture decoded head, or drop valid after a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      alu_q   <= `ALU_ADD;
      src_q   <= 1'b0;
      we_q    <= 1'b0;
      dst_q   <= 1'b0;
      sys_q   <= 1'b0;
      ri_q    <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      pc_q    <= pc_mem[rd_ptr_q];
      rs_q    <= head_inst[25:21];
      rt_q    <= head_inst[20:16];
      rd_q    <= head_inst[15:11];
      imm_q   <= dec_imm;
      alu_q   <= dec_alu;
      src_q   <= dec_src;
      we_q    <= dec_we;
      dst_q   <= dec_dst;
      sys_q   <= dec_sys;
      ri_q    <= dec_ri;
    end else if (hs) begin
      valid_q <= 1'b0;
    end
  end

  // Run/halt next-state: flush always returns to RUN.
  always_comb begin
    state_d = state_q;
    if (flush)        state_d = ST_RUN;
    else if (halting) state_d = ST_HALT;
  end

  // Run/halt state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

`ifdef MIPS_DECODE_PERF_EN
  logic [31:0] perf_issued_q;
  logic [15:0] perf_ri_q;

  // Issue counters survive flush; a handshake discarded by flush is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued_q <= '0;
      perf_ri_q     <= '0;
    end else if (hs && !flush) begin
      perf_issued_q <= perf_issued_q + 32'd1;
      if (ri_q) perf_ri_q <= perf_ri_q + 16'd1;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_ri     = perf_ri_q;
`endif

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_rs      = rs_q;
  assign out_rt      = rt_q;
  assign out_rd      = rd_q;
  assign out_imm     = imm_q;
  assign out_alu_sel = alu_q;
  assign out_alu_src = src_q;
  assign out_we      = we_q;
  assign out_dst_rt  = dst_q;
  assign out_sys     = sys_q;
  assign out_ri      = ri_q;
  assign halted      = (state_q == ST_HALT);
  assign count       = count_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_decode_queue
// Purpose  : Self-checking bench for mips_decode_queue: directed scenarios
//            plus randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_decode_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam logic [3:0] A_ADD = 4'd0, A_ADDU = 4'd1, A_AND = 4'd4, A_OR = 4'd5, A_XOR = 4'd6;

  logic            clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0]     in_inst = '0;
  logic [PC_W-1:0] in_pc = '0;
  logic            in_ready, out_valid, out_alu_src, out_we, out_dst_rt, out_sys, out_ri, halted;
  logic [PC_W-1:0] out_pc;
  logic [4:0]      out_rs, out_rt, out_rd;
  logic [31:0]     out_imm;
  logic [3:0]      out_alu_sel;
  logic [2:0]      count;
`ifdef MIPS_DECODE_PERF_EN
  logic [31:0]     perf_issued;
  logic [15:0]     perf_ri;
`endif

  always #5 clk = ~clk;

  mips_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .SYS_HALT(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_imm(out_imm),
    .out_alu_sel(out_alu_sel), .out_alu_src(out_alu_src), .out_we(out_we),
    .out_dst_rt(out_dst_rt), .out_sys(out_sys), .out_ri(out_ri), .halted(halted),
`ifdef MIPS_DECODE_PERF_EN
    .perf_issued(perf_issued), .perf_ri(perf_ri),
`endif
    .count(count)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: queue of pending instructions, one output slot, halt flag.
  typedef struct packed { logic [PC_W-1:0] pc; logic [31:0] inst; } entry_t;
  entry_t m_q[$];
  entry_t m_slot;
  logic   m_valid, m_halt;
  logic   pre_ready, pre_valid;
  logic [PC_W-1:0] pre_pc;

  wire [PC_W+55:0] dut_vec = {out_pc, out_rs, out_rt, out_rd, out_imm, out_alu_sel,
                              out_alu_src, out_we, out_dst_rt, out_sys, out_ri};

  // Returns {rs, rt, rd, imm, alu, alu_src, we, dst_rt, sys, ri}.
  function automatic logic [55:0] dec_ref(input logic [31:0] inst);
    logic [5:0]  op, fn;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic        src, we, dst, sys, ri, zx;
    op = inst[31:26]; fn = inst[5:0];
    alu = A_ADD; src = 0; we = 0; dst = 0; sys = 0; ri = 0; zx = 0;
    if (op == 6'h00) begin
      if (fn >= 6'h20 && fn <= 6'h26) begin we = 1; alu = 4'(fn - 6'h20); end
      else if (fn == 6'h0C) sys = 1;
      else ri = 1;
    end else if (op == 6'h08 || op == 6'h09) begin
      we = 1; src = 1; dst = 1; alu = (op == 6'h08) ? A_ADD : A_ADDU;
    end else if (op >= 6'h0C && op <= 6'h0E) begin
      we = 1; src = 1; dst = 1; zx = 1; alu = A_AND + 4'(op - 6'h0C);
    end else ri = 1;
    imm = zx ? {16'h0, inst[15:0]} : 32'(signed'(inst[15:0]));
    return {inst[25:21], inst[20:16], inst[15:11], imm, alu, src, we, dst, sys, ri};
  endfunction

  task automatic model_clear();
    m_q.delete(); m_valid = 0; m_halt = 0; m_slot = '0;
  endtask

  task automatic model_step(input logic iv, input logic [31:0] ii, input logic [PC_W-1:0] ip,
                            input logic ordy, input logic fl);
    logic ready, push, hs, halting, load;
    logic [55:0] d;
    entry_t e;
    ready = (m_q.size() < DEPTH) && !m_halt;
    push  = iv && ready;
    hs    = m_valid && ordy;
    d     = dec_ref(m_slot.inst);
    if (fl) begin
      model_clear();
    end else begin
      halting = hs && d[1];
      load = (m_q.size() > 0) && !m_halt && (!m_valid || ordy) && !halting;
      if (load) begin m_slot = m_q.pop_front(); m_valid = 1; end
      else if (hs) m_valid = 0;
      if (halting) m_halt = 1;
      if (push) begin e.pc = ip; e.inst = ii; m_q.push_back(e); end
    end
  endtask

  // One clock: drive inputs, sample pre-edge status, advance model with the edge.
  task automatic cycle(input logic iv, input logic [31:0] ii, input logic [PC_W-1:0] ip,
                       input logic ordy, input logic fl);
    in_valid = iv; in_inst = ii; in_pc = ip; out_ready = ordy; flush = fl;
    #1;
    pre_ready = in_ready; pre_valid = out_valid; pre_pc = out_pc;
    @(posedge clk);
    model_step(iv, ii, ip, ordy, fl);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({out_valid, count, halted} !== 5'b0) begin errors++;
      $display("FAIL reset_status: got %b want 00000", {out_valid, count, halted}); end
    checks++; if (dut_vec !== '0) begin errors++;
      $display("FAIL reset_fields: got %h want 0", dut_vec); end
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk); rst = 1'b0;
    model_clear();
  endtask

  task automatic test_addi();
    cycle(0, 0, 0, 1, 1);
    cycle(1, 32'h2008_0005, 32'h100, 1, 0);
    checks++; if ({out_valid, count} !== 4'b0001) begin errors++;
      $display("FAIL addi_latency: got valid/count %b want 0001", {out_valid, count}); end
    cycle(0, 0, 0, 1, 0);
    checks++; if ({out_valid, out_alu_sel, out_imm, out_rt, out_we, out_dst_rt, out_alu_src, out_pc}
                  !== {1'b1, A_ADD, 32'h5, 5'd8, 1'b1, 1'b1, 1'b1, 32'h100}) begin errors++;
      $display("FAIL addi_decode: got %h want %h",
               {out_valid, out_alu_sel, out_imm, out_rt, out_we, out_dst_rt, out_alu_src, out_pc},
               {1'b1, A_ADD, 32'h5, 5'd8, 1'b1, 1'b1, 1'b1, 32'h100}); end
    cycle(0, 0, 0, 1, 0);
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL addi_drain: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    cycle(0, 0, 0, 1, 1);
    cycle(1, 32'h3109_FFFF, 32'h200, 1, 0);
    cycle(1, 32'h2109_FFFF, 32'h204, 1, 0);
    checks++; if ({out_valid, out_pc, out_imm, out_alu_sel} !== {1'b1, 32'h200, 32'h0000_FFFF, A_AND}) begin
      errors++; $display("FAIL b2b_andi: got %h want %h", {out_valid, out_pc, out_imm, out_alu_sel},
                         {1'b1, 32'h200, 32'h0000_FFFF, A_AND}); end
    cycle(0, 0, 0, 1, 0);
    checks++; if ({out_valid, out_pc, out_imm, out_alu_sel} !== {1'b1, 32'h204, 32'hFFFF_FFFF, A_ADD}) begin
      errors++; $display("FAIL b2b_addi: got %h want %h", {out_valid, out_pc, out_imm, out_alu_sel},
                         {1'b1, 32'h204, 32'hFFFF_FFFF, A_ADD}); end
    cycle(0, 0, 0, 1, 0);
  endtask

  task automatic test_full();
    int accepted;
    logic [PC_W-1:0] got[$];
    accepted = 0;
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 32'h0109_5021, 32'h300 + 32'(4 * i), 0, 0);
      if (pre_ready) accepted++;
    end
    checks++; if (accepted !== 5) begin errors++;
      $display("FAIL full_accepted: got %0d want 5", accepted); end
    checks++; if ({count, in_ready} !== {3'd4, 1'b0}) begin errors++;
      $display("FAIL full_status: got count %0d in_ready %b want 4 0", count, in_ready); end
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0, 1, 0);
      if (pre_valid) got.push_back(pre_pc);
    end
    checks++; if (got.size() !== 5) begin errors++;
      $display("FAIL full_drain_count: got %0d want 5", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== 32'h300 + 32'(4 * i)) begin errors++;
        $display("FAIL full_order[%0d]: got %h want %h", i, got[i], 32'h300 + 32'(4 * i)); end
    end
  endtask

  task automatic test_syscall_halt();
    cycle(0, 0, 0, 1, 1);
    cycle(1, 32'h0000_000C, 32'h400, 1, 0);
    cycle(1, 32'h0109_5021, 32'h404, 1, 0);
    checks++; if ({out_valid, out_sys, out_we, out_pc} !== {3'b110, 32'h400}) begin errors++;
      $display("FAIL sys_slot: got %h want %h", {out_valid, out_sys, out_we, out_pc}, {3'b110, 32'h400}); end
    repeat (3) cycle(0, 0, 0, 1, 0);
    checks++; if ({halted, in_ready, out_valid, count} !== {3'b100, 3'd1}) begin errors++;
      $display("FAIL sys_halted: got %b want 100001", {halted, in_ready, out_valid, count}); end
    cycle(0, 0, 0, 1, 1);
    checks++; if ({halted, in_ready, out_valid, count} !== {3'b010, 3'd0}) begin errors++;
      $display("FAIL sys_flush: got %b want 010000", {halted, in_ready, out_valid, count}); end
  endtask

  task automatic test_ri();
    cycle(0, 0, 0, 1, 1);
    cycle(1, 32'h8D09_0000, 32'h500, 1, 0);
    cycle(1, 32'h2009_0007, 32'h504, 1, 0);
    checks++; if ({out_valid, out_ri, out_we, out_alu_src} !== 4'b1100) begin errors++;
      $display("FAIL ri_slot: got %b want 1100", {out_valid, out_ri, out_we, out_alu_src}); end
    cycle(0, 0, 0, 1, 0);
    checks++; if ({out_valid, out_ri, halted, out_pc} !== {3'b100, 32'h504}) begin errors++;
      $display("FAIL ri_continue: got %h want %h", {out_valid, out_ri, halted, out_pc}, {3'b100, 32'h504}); end
    cycle(0, 0, 0, 1, 0);
  endtask

  task automatic test_flush_same_cycle();
    cycle(0, 0, 0, 0, 1);
    cycle(1, 32'h2008_0001, 32'h600, 0, 0);
    cycle(1, 32'h2008_0002, 32'h604, 0, 0);
    cycle(1, 32'h2008_0003, 32'h608, 1, 1);
    checks++; if ({out_valid, count} !== 4'b0000) begin errors++;
      $display("FAIL flush_same: got valid/count %b want 0000", {out_valid, count}); end
    cycle(0, 0, 0, 1, 0);
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL flush_no_reload: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_random();
    logic [5:0] ops[10];
    logic [5:0] fns[10];
    logic [31:0] inst;
    logic exp_ready;
    ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h3F};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h0C};
    cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < 400; i++) begin
      inst = $urandom;
      inst[31:26] = ops[$urandom_range(0, 9)];
      if (inst[31:26] == 6'h00) inst[5:0] = fns[($urandom_range(0, 19) == 0) ? 9 : $urandom_range(0, 8)];
      exp_ready = (m_q.size() < DEPTH) && !m_halt;
      cycle(($urandom_range(0, 9) < 7), inst, $urandom, ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 39) == 0));
      checks++; if (pre_ready !== exp_ready) begin errors++;
        $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, pre_ready, exp_ready); end
      checks++; if ({out_valid, halted} !== {m_valid, m_halt}) begin errors++;
        $display("FAIL rnd_status[%0d]: got %b want %b", i, {out_valid, halted}, {m_valid, m_halt}); end
      checks++; if (int'(count) !== m_q.size()) begin errors++;
        $display("FAIL rnd_count[%0d]: got %0d want %0d", i, count, m_q.size()); end
      if (m_valid) begin
        checks++; if (dut_vec !== {m_slot.pc, dec_ref(m_slot.inst)}) begin errors++;
          $display("FAIL rnd_slot[%0d]: got %h want %h", i, dut_vec, {m_slot.pc, dec_ref(m_slot.inst)}); end
      end
    end
  endtask

  task automatic test_reset_midop();
    cycle(0, 0, 0, 0, 1);
    cycle(1, 32'h2008_0001, 32'h700, 0, 0);
    cycle(1, 32'h2008_0002, 32'h704, 0, 0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if ({out_valid, count, halted} !== 5'b0 || dut_vec !== '0) begin errors++;
      $display("FAIL reset_midop: got status %b fields %h want 0", {out_valid, count, halted}, dut_vec); end
    @(negedge clk); rst = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_addi();
    test_back_to_back();
    test_full();
    test_syscall_halt();
    test_ri();
    test_flush_same_cycle();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
